// File: rtl/cfg_word_loader.sv
// cfg_word_loader: sequences a word stream onto a bank of transparent
// configuration latches. Each accepted word is presented on io_d_out for a
// setup cycle, strobed into latch idx with a one-cycle one-hot enable, and
// held for one more cycle before the next word is accepted.
//
// Optional build macro CFG_LOADER_CHECKSUM_EN: the stream carries one extra
// trailing word, the XOR of all data words; a mismatch sets the sticky io_err.
// Without the macro io_err is tied low.
module cfg_word_loader #(
    parameter int NUM_WORDS = 21,
    parameter int WORD_W    = 32,
    parameter int IDX_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [WORD_W-1:0]    io_in_bits,
    output logic [WORD_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_CHK,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [NUM_WORDS-1:0] EN_ONE   = NUM_WORDS'(1);

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [WORD_W-1:0]      d_out, d_out_nxt;
    logic [NUM_WORDS-1:0]   en, en_nxt;
    logic                   ready, ready_nxt;
    logic                   busy, busy_nxt;
    logic                   done, done_nxt;
`ifdef CFG_LOADER_CHECKSUM_EN
    logic                   err, err_nxt;
    logic [WORD_W-1:0]      xor_acc, xor_nxt;
`endif

    // Next-state and next-output logic; every output is registered below, so
    // the enable strobe is glitch-free at the latch bank.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        idx_nxt   = idx;
        d_out_nxt = d_out;
        en_nxt    = '0;
        ready_nxt = 1'b0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
        err_nxt   = err;
        xor_nxt   = xor_acc;
`endif
        unique case (state)
            S_IDLE: begin
                if (io_start) begin
                    state_nxt = S_WAIT;
                    busy_nxt  = 1'b1;
                    idx_nxt   = '0;
                    ready_nxt = 1'b1;
`ifdef CFG_LOADER_CHECKSUM_EN
                    err_nxt   = 1'b0;
                    xor_nxt   = '0;
`endif
                end
            end
            S_WAIT: begin
                ready_nxt = 1'b1;
                if (io_in_valid && ready) begin
                    d_out_nxt = io_in_bits;
                    state_nxt = S_SETUP;
                    ready_nxt = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
                    xor_nxt   = xor_acc ^ io_in_bits;
`endif
                end
            end
            S_SETUP: begin
                // Data has been stable for a full cycle; raise the enable.
                state_nxt = S_STROBE;
                en_nxt    = EN_ONE << idx;
            end
            S_STROBE: begin
                // Enable drops while data stays put, giving hold margin.
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (idx == LAST_IDX) begin
`ifdef CFG_LOADER_CHECKSUM_EN
                    state_nxt = S_CHK;
                    ready_nxt = 1'b1;
`else
                    state_nxt = S_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
`endif
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = S_WAIT;
                    ready_nxt = 1'b1;
                end
            end
            S_CHK: begin
`ifdef CFG_LOADER_CHECKSUM_EN
                ready_nxt = 1'b1;
                if (io_in_valid && ready) begin
                    // Checksum word is compared only; the latch bus keeps the last data word.
                    err_nxt   = (io_in_bits != xor_acc);
                    state_nxt = S_DONE;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
`else
                state_nxt = S_IDLE;
`endif
            end
            S_DONE: begin
                // io_start seen here is deliberately dropped.
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            d_out   <= '0;
            en      <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
            err     <= 1'b0;
            xor_acc <= '0;
`endif
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            d_out   <= d_out_nxt;
            en      <= en_nxt;
            ready   <= ready_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
`ifdef CFG_LOADER_CHECKSUM_EN
            err     <= err_nxt;
            xor_acc <= xor_nxt;
`endif
        end
    end

    assign io_in_ready   = ready;
    assign io_d_out      = d_out;
    assign io_configs_en = en;
    assign io_busy       = busy;
    assign io_done       = done;
`ifdef CFG_LOADER_CHECKSUM_EN
    assign io_err        = err;
`else
    assign io_err        = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_word_loader.sv
// Scoreboard bench for cfg_word_loader. The stimulus side pushes the expected
// (index, word) of every strobe and the expected completion of every load;
// an independent negedge monitor pops and compares whenever the DUT strobes
// or pulses io_done.
module tb_cfg_word_loader;

    localparam int NUM_WORDS = 21;
    localparam int WORD_W    = 32;
    localparam int IDX_W     = 5;
`ifdef CFG_LOADER_CHECKSUM_EN
    localparam int CHK_WORDS = 1;
`else
    localparam int CHK_WORDS = 0;
`endif

    logic                 clk;
    logic                 reset;
    logic                 io_start;
    logic                 io_in_valid;
    logic                 io_in_ready;
    logic [WORD_W-1:0]    io_in_bits;
    logic [WORD_W-1:0]    io_d_out;
    logic [NUM_WORDS-1:0] io_configs_en;
    logic                 io_busy;
    logic                 io_done;
    logic                 io_err;

    cfg_word_loader #(
        .NUM_WORDS(NUM_WORDS),
        .WORD_W   (WORD_W),
        .IDX_W    (IDX_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io_start     (io_start),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_bits   (io_in_bits),
        .io_d_out     (io_d_out),
        .io_configs_en(io_configs_en),
        .io_busy      (io_busy),
        .io_done      (io_done),
        .io_err       (io_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int                idx;
        logic [WORD_W-1:0] data;
    } strobe_t;

    typedef struct {
        bit timed;
        int latency;
        bit err;
    } done_t;

    strobe_t strobe_q[$];
    done_t   done_q[$];

    int                cyc = 0;
    int                start_cyc = 0;
    int                strobe_cnt = 0;
    bit                in_load = 1'b0;
    bit                after_strobe = 1'b0;
    logic [WORD_W-1:0] strobe_data = '0;
    logic [WORD_W-1:0] prev_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares each strobe and each done pulse against the queues.
    always @(negedge clk) begin
        strobe_t              s;
        done_t                d;
        logic [NUM_WORDS-1:0] one_hot;
        if (!reset) begin
            if (after_strobe) begin
                check("post_strobe_en", 64'(io_configs_en), 64'd0);
                check("post_strobe_data", 64'(io_d_out), 64'(strobe_data));
                after_strobe = 1'b0;
            end
            if (io_configs_en != '0) begin
                strobe_cnt++;
                if (strobe_q.size() == 0) begin
                    check("unexpected_strobe", 64'(io_configs_en), 64'd0);
                end else begin
                    s       = strobe_q.pop_front();
                    one_hot = '0;
                    one_hot[s.idx] = 1'b1;
                    check("strobe_en", 64'(io_configs_en), 64'(one_hot));
                    check("strobe_data", 64'(io_d_out), 64'(s.data));
                    check("pre_strobe_data", 64'(prev_d), 64'(s.data));
                    strobe_data  = s.data;
                    after_strobe = 1'b1;
                end
            end
            if (io_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'(io_done), 64'd0);
                end else begin
                    d = done_q.pop_front();
                    check("done_busy_low", 64'(io_busy), 64'd0);
                    check("done_err", 64'(io_err), 64'(d.err));
                    // Latency counts to the edge that closes the done cycle.
                    if (d.timed)
                        check("done_latency", 64'(cyc - start_cyc + 1), 64'(d.latency));
                end
                in_load = 1'b0;
            end else if (in_load) begin
                check("busy_during_load", 64'(io_busy), 64'd1);
            end
        end
        prev_d = io_d_out;
    end

    // Offer one word after gap idle cycles; returns just after the transfer edge.
    task automatic send_word(input logic [WORD_W-1:0] w, input int gap);
        int budget;
        io_in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        io_in_valid = 1'b1;
        io_in_bits  = w;
        budget      = 0;
        @(negedge clk);
        while (!io_in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!io_in_ready) check("handshake_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        io_in_valid = 1'b0;
    endtask

    // One complete load. timed: fixed words 0x1000_0000+k, back-to-back, latency checked.
    task automatic run_load(input int max_gap, input bit timed, input bit corrupt,
                            input bit start_mid, input bit start_at_done);
        logic [WORD_W-1:0] words [NUM_WORDS];
        logic [WORD_W-1:0] x;
        int                budget;
        done_t             d;
        x = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            words[k] = timed ? (32'h1000_0000 + 32'(k)) : $urandom;
            x ^= words[k];
        end
        // Back-to-back: 4 cycles per word, plus one for the trailing checksum word.
        d.timed   = timed;
        d.latency = 4 * NUM_WORDS + 1 + CHK_WORDS;
        d.err     = (CHK_WORDS != 0) && corrupt;
        done_q.push_back(d);
        strobe_cnt = 0;

        io_start = 1'b1;
        @(posedge clk);
        #1;
        io_start  = 1'b0;
        start_cyc = cyc;
        in_load   = 1'b1;
        check("err_cleared_on_start", 64'(io_err), 64'd0);

        for (int k = 0; k < NUM_WORDS; k++) begin
            strobe_t s;
            s.idx  = k;
            s.data = words[k];
            strobe_q.push_back(s);
            if (start_mid && k == 5) io_start = 1'b1;
            send_word(words[k], timed ? 0 : int'($urandom_range(0, max_gap)));
            io_start = 1'b0;
        end
`ifdef CFG_LOADER_CHECKSUM_EN
        send_word(corrupt ? (x ^ 32'h1) : x, timed ? 0 : int'($urandom_range(0, max_gap)));
`endif

        budget = 0;
        @(negedge clk);
        while (!io_done && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!io_done) check("done_timeout", 64'd0, 64'd1);
        if (start_at_done) io_start = 1'b1;
        @(posedge clk);
        #1;
        io_start = 1'b0;
        @(negedge clk);
        check("strobe_count", 64'(strobe_cnt), 64'(NUM_WORDS));
        check("strobe_q_empty", 64'(strobe_q.size()), 64'd0);
        check("last_word_kept", 64'(io_d_out), 64'(words[NUM_WORDS-1]));
        check("idle_busy", 64'(io_busy), 64'd0);
        check("idle_ready", 64'(io_in_ready), 64'd0);
        @(negedge clk);
        check("still_idle_busy", 64'(io_busy), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        io_start    = 1'b0;
        io_in_valid = 1'b0;
        io_in_bits  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset: nothing moves even with valid asserted.
        io_in_valid = 1'b1;
        io_in_bits  = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_in_ready", 64'(io_in_ready), 64'd0);
            check("idle_en", 64'(io_configs_en), 64'd0);
            check("idle_d_out", 64'(io_d_out), 64'd0);
            check("idle_flags", 64'({io_busy, io_done, io_err}), 64'd0);
        end
        @(posedge clk);
        #1;
        io_in_valid = 1'b0;

        run_load(0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_load(7, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CFG_LOADER_CHECKSUM_EN
        run_load(0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("err_sticky", 64'(io_err), 64'd1);
        end
        @(posedge clk);
        #1;
`endif
        run_load(3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_load(7, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset while word 10 sits in SETUP: its strobe must never appear.
        strobe_cnt = 0;
        io_start   = 1'b1;
        @(posedge clk);
        #1;
        io_start = 1'b0;
        in_load  = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            strobe_t s;
            s.idx  = k;
            s.data = $urandom;
            strobe_q.push_back(s);
            send_word(s.data, int'($urandom_range(0, 3)));
        end
        in_load = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        check("rst_en_zero", 64'(io_configs_en), 64'd0);
        check("rst_d_out_zero", 64'(io_d_out), 64'd0);
        check("rst_busy_zero", 64'(io_busy), 64'd0);
        check("rst_ready_zero", 64'(io_in_ready), 64'd0);
        check("rst_strobes_before", 64'(strobe_cnt), 64'd10);
        check("rst_pending_word", 64'(strobe_q.size()), 64'd1);
        strobe_q.delete();
        @(posedge clk);
        #1;
        check("rst_en_still_zero", 64'(io_configs_en), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", 64'({io_busy, io_in_ready, io_done}), 64'd0);

        run_load(0, 1'b1, 1'b0, 1'b0, 1'b0);

        check("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
